// File: rtl/datapath_ctrl.sv
// Instruction decoder and multi-cycle control FSM for the 16-bit register/ALU datapath.
// Accepts one instruction per start handshake and drives every datapath control input.
module datapath_ctrl #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [DW-1:0] instr,
    output logic          w,
    output logic          illegal,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic          vsel,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [DW-1:0] datapath_in
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [DW-1:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic [7:0] imm8;

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign imm8   = ir[7:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // IR only captures on the accept edge, so instr may change freely mid-instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if ((state == S_WAIT) && s) begin
            ir <= instr;
        end
    end

    always_comb begin
        next_state  = state;
        w           = 1'b0;
        illegal     = 1'b0;
        readnum     = 3'd0;
        writenum    = 3'd0;
        write       = 1'b0;
        vsel        = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        shift       = 2'b00;
        ALUop       = 2'b00;
        datapath_in = '0;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) next_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    next_state = S_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    next_state = S_GET_B;
                end else if (is_alu) begin
                    next_state = S_GET_A;
                end else begin
                    illegal    = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                shift = sh;
                if (is_mov_reg) begin
                    asel       = 1'b1;
                    loadc      = 1'b1;
                    next_state = S_WRITE_REG;
                end else if (is_cmp) begin
                    // CMP only updates status; nothing is written back
                    ALUop      = 2'b01;
                    loads      = 1'b1;
                    next_state = S_WAIT;
                end else if (is_mvn) begin
                    ALUop      = 2'b11;
                    loadc      = 1'b1;
                    next_state = S_WRITE_REG;
                end else begin
                    ALUop      = op;
                    loadc      = 1'b1;
                    next_state = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                writenum   = rd;
                write      = 1'b1;
                next_state = S_WAIT;
            end
            S_WRITE_IMM: begin
                vsel        = 1'b1;
                writenum    = rn;
                write       = 1'b1;
                datapath_in = {{(DW-8){imm8[7]}}, imm8};
                next_state  = S_WAIT;
            end
            default: begin
                next_state = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: stimulus queues per-cycle expected control vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic [15:0] instr = 16'h0000;

    logic        w, illegal, write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    typedef struct packed {
        logic        w;
        logic        illegal;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  alu_op;
        logic [15:0] datapath_in;
    } ctrl_t;

    typedef struct packed {
        logic [15:0] code;
        logic [3:0]  step;
        ctrl_t       ctrl;
    } sb_t;

    sb_t   sb_q[$];
    ctrl_t trace_q[$];
    sb_t   mon_e;
    int    n_checks = 0;
    int    n_fails = 0;

    datapath_ctrl #(.DW(16)) dut (
        .clk(clk), .reset(reset), .s(s), .instr(instr),
        .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t c_zero();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

    function automatic ctrl_t c_wait();
        ctrl_t c;
        c = '0;
        c.w = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_ill();
        ctrl_t c;
        c = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_get_a(input logic [2:0] rn);
        ctrl_t c;
        c = '0;
        c.readnum = rn;
        c.loada = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_get_b(input logic [2:0] rm);
        ctrl_t c;
        c = '0;
        c.readnum = rm;
        c.loadb = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_exec(input logic [1:0] sh, input logic as, input logic [1:0] alu,
                                     input logic lc, input logic ls);
        ctrl_t c;
        c = '0;
        c.shift = sh;
        c.asel = as;
        c.alu_op = alu;
        c.loadc = lc;
        c.loads = ls;
        return c;
    endfunction

    function automatic ctrl_t c_wreg(input logic [2:0] rd);
        ctrl_t c;
        c = '0;
        c.writenum = rd;
        c.write = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_wimm(input logic [2:0] rn, input logic [15:0] val);
        ctrl_t c;
        c = '0;
        c.writenum = rn;
        c.write = 1'b1;
        c.vsel = 1'b1;
        c.datapath_in = val;
        return c;
    endfunction

    function automatic ctrl_t sample();
        ctrl_t c;
        c.w = w;
        c.illegal = illegal;
        c.readnum = readnum;
        c.writenum = writenum;
        c.write = write;
        c.vsel = vsel;
        c.loada = loada;
        c.loadb = loadb;
        c.loadc = loadc;
        c.loads = loads;
        c.asel = asel;
        c.bsel = bsel;
        c.shift = shift;
        c.alu_op = ALUop;
        c.datapath_in = datapath_in;
        return c;
    endfunction

    task automatic checkOutput(input string name, input ctrl_t exp);
        ctrl_t act;
        act = sample();
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input ctrl_t c);
        trace_q.push_back(c);
    endtask

    // Accepts one instruction, then hands the prepared trace to the scoreboard.
    task automatic applyStimulus(input logic [15:0] code, input bit hold);
        sb_t e;
        int  step;
        @(negedge clk);
        instr = code;
        s = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) s = 1'b0;
        step = 0;
        while (trace_q.size() != 0) begin
            e.code = code;
            e.step = step[3:0];
            e.ctrl = trace_q.pop_front();
            sb_q.push_back(e);
            step++;
        end
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 64 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL %s_timeout: %0d entries left, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checkOutput($sformatf("instr_%h_step%0d", mon_e.code, mon_e.step), mon_e.ctrl);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 checkOutput("reset_hold", c_wait());
        @(negedge clk) reset = 1'b0;
        #1 checkOutput("reset_release", c_wait());
        @(posedge clk);
        #1 checkOutput("idle_no_s", c_wait());

        add(c_zero()); add(c_wimm(3'd0, 16'h0007)); add(c_wait());
        applyStimulus(16'hD007, 1'b0); waitDrain("mov_imm_7");

        add(c_zero()); add(c_wimm(3'd1, 16'hFFFE)); add(c_wait());
        applyStimulus(16'hD1FE, 1'b0); waitDrain("mov_imm_neg");

        add(c_zero()); add(c_get_a(3'd1)); add(c_get_b(3'd0));
        add(c_exec(2'b01, 1'b0, 2'b00, 1'b1, 1'b0)); add(c_wreg(3'd2)); add(c_wait());
        applyStimulus(16'hA148, 1'b0); waitDrain("add");

        add(c_zero()); add(c_get_a(3'd0)); add(c_get_b(3'd0));
        add(c_exec(2'b00, 1'b0, 2'b01, 1'b0, 1'b1)); add(c_wait());
        applyStimulus(16'hA800, 1'b0); waitDrain("cmp");

        add(c_zero()); add(c_get_b(3'd1));
        add(c_exec(2'b00, 1'b0, 2'b11, 1'b1, 1'b0)); add(c_wreg(3'd7)); add(c_wait());
        applyStimulus(16'hB8E1, 1'b0); waitDrain("mvn");

        add(c_zero()); add(c_get_b(3'd5));
        add(c_exec(2'b10, 1'b1, 2'b00, 1'b1, 1'b0)); add(c_wreg(3'd3)); add(c_wait());
        applyStimulus(16'hC075, 1'b0); waitDrain("mov_reg");

        add(c_zero()); add(c_get_a(3'd2)); add(c_get_b(3'd6));
        add(c_exec(2'b11, 1'b0, 2'b10, 1'b1, 1'b0)); add(c_wreg(3'd4)); add(c_wait());
        applyStimulus(16'hB29E, 1'b0); waitDrain("and");

        add(c_ill()); add(c_wait());
        applyStimulus(16'h0000, 1'b0); waitDrain("illegal_0000");
        add(c_ill()); add(c_wait());
        applyStimulus(16'hF000, 1'b0); waitDrain("illegal_f000");
        add(c_ill()); add(c_wait());
        applyStimulus(16'hD800, 1'b0); waitDrain("illegal_d800");

        // s held high: instr swapped during GET_A, MOV #5 follows straight after ADD
        add(c_zero()); add(c_get_a(3'd1)); add(c_get_b(3'd0));
        add(c_exec(2'b01, 1'b0, 2'b00, 1'b1, 1'b0)); add(c_wreg(3'd2)); add(c_wait());
        add(c_zero()); add(c_wimm(3'd0, 16'h0005)); add(c_wait());
        applyStimulus(16'hA148, 1'b1);
        @(posedge clk);
        #1 instr = 16'hD005;
        repeat (4) @(posedge clk);
        @(posedge clk);
        #1 s = 1'b0;
        waitDrain("back_to_back");

        @(negedge clk);
        instr = 16'hA148;
        s = 1'b1;
        @(posedge clk);
        #1 s = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("exec_before_reset", c_exec(2'b01, 1'b0, 2'b00, 1'b1, 1'b0));
        #1 reset = 1'b1;
        #1 checkOutput("reset_async_exec", c_wait());
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_in_exec_hold%0d", i), c_wait());
        end
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset_idle%0d", i), c_wait());
        end

        add(c_zero()); add(c_wimm(3'd1, 16'h007F)); add(c_wait());
        applyStimulus(16'hD17F, 1'b0); waitDrain("first_after_reset");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
